// File: rtl/q_episode_scheduler.sv
// Episode/step sequencer for Q-learning training on a ROWS x COLS grid:
// epsilon-greedy action choice, next-state/reward generation, one datapath update per step.
module q_episode_scheduler #(
    parameter int ROWS        = 5,
    parameter int COLS        = 5,
    parameter int ACTIONS     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int GOAL_ROW    = 4,
    parameter int GOAL_COL    = 4,
    parameter int GOAL_REWARD = 10,
    parameter int MAX_STEPS   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [7:0]                    num_episodes,
    input  logic [7:0]                    epsilon,
    input  logic [ACTIONS*DATA_WIDTH-1:0] q_vals,
    input  logic                          upd_ready,
    output logic                          upd_valid,
    output logic [2:0]                    row,
    output logic [2:0]                    col,
    output logic [1:0]                    action,
    output logic [2:0]                    next_row,
    output logic [2:0]                    next_col,
    output logic [DATA_WIDTH-1:0]         reward,
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    episode_cnt,
    output logic [7:0]                    step_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic        upd_valid_nxt, busy_nxt, done_nxt;
    logic [15:0] lfsr;
    logic [7:0]  num_eps_q;
    logic [7:0]  eps_q;
    logic [1:0]  sel_action;
    logic [2:0]  sel_nrow, sel_ncol;
    logic        sel_goal;
    logic        ep_end;
    logic [7:0]  ep_cnt_inc;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Strict '>' keeps the lowest index on ties.
    function automatic logic [1:0] greedy_pick(input logic [ACTIONS*DATA_WIDTH-1:0] q);
        logic [1:0]            best;
        logic [DATA_WIDTH-1:0] best_v;
        best   = 2'd0;
        best_v = q[DATA_WIDTH-1:0];
        for (int a = 1; a < ACTIONS; a++) begin
            if (q[a*DATA_WIDTH +: DATA_WIDTH] > best_v) begin
                best   = 2'(a);
                best_v = q[a*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return best;
    endfunction

    function automatic logic [2:0] move_row(input logic [2:0] r, input logic [1:0] a);
        logic [2:0] res;
        res = r;
        if (a == 2'd0 && r != 3'd0)                res = r - 3'd1;
        else if (a == 2'd1 && r != 3'(ROWS - 1))   res = r + 3'd1;
        return res;
    endfunction

    function automatic logic [2:0] move_col(input logic [2:0] c, input logic [1:0] a);
        logic [2:0] res;
        res = c;
        if (a == 2'd2 && c != 3'(COLS - 1))        res = c + 3'd1;
        else if (a == 2'd3 && c != 3'd0)          res = c - 3'd1;
        return res;
    endfunction

    assign sel_action = (lfsr[7:0] < eps_q) ? lfsr[9:8] : greedy_pick(q_vals);
    assign sel_nrow   = move_row(row, sel_action);
    assign sel_ncol   = move_col(col, sel_action);
    assign sel_goal   = (sel_nrow == 3'(GOAL_ROW)) && (sel_ncol == 3'(GOAL_COL));
    assign ep_end     = ((next_row == 3'(GOAL_ROW)) && (next_col == 3'(GOAL_COL)))
                        || (step_cnt == 8'(MAX_STEPS - 1));
    assign ep_cnt_inc = episode_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            upd_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            upd_valid <= upd_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Control outputs are decoded from the next state so they are registered with it.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = (num_episodes == 8'd0) ? S_DONE : S_SELECT;
            S_SELECT:  state_nxt = S_ISSUE;
            S_ISSUE:   if (upd_ready) state_nxt = S_ADVANCE;
            S_ADVANCE: state_nxt = (ep_end && ep_cnt_inc == num_eps_q) ? S_DONE : S_SELECT;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        upd_valid_nxt = (state_nxt == S_ISSUE);
        done_nxt      = (state_nxt == S_DONE);
        busy_nxt      = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr        <= 16'hACE1;
            num_eps_q   <= '0;
            eps_q       <= '0;
            row         <= '0;
            col         <= '0;
            action      <= '0;
            next_row    <= '0;
            next_col    <= '0;
            reward      <= '0;
            episode_cnt <= '0;
            step_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_eps_q   <= num_episodes;
                        eps_q       <= epsilon;
                        episode_cnt <= '0;
                        step_cnt    <= '0;
                        row         <= '0;
                        col         <= '0;
                    end
                end
                S_SELECT: begin
                    lfsr     <= lfsr_step(lfsr);
                    action   <= sel_action;
                    next_row <= sel_nrow;
                    next_col <= sel_ncol;
                    reward   <= sel_goal ? DATA_WIDTH'(GOAL_REWARD) : '0;
                end
                S_ADVANCE: begin
                    if (ep_end) begin
                        episode_cnt <= ep_cnt_inc;
                        step_cnt    <= '0;
                        row         <= '0;
                        col         <= '0;
                    end else begin
                        row      <= next_row;
                        col      <= next_col;
                        step_cnt <= step_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
